// File: rtl/multi_traffic_receiver.sv
// Multi-port PIFO dequeue driver: random, greedy, burst/gap and halt ejection
// modes with per-port packet counting and priority-order checking.
module multi_traffic_receiver #(
   parameter int NUM_PORTS = 2,
   parameter int FLOW_W    = 8,
   parameter int PRIO_W    = 16,
   parameter int RATE_W    = 8,
   parameter int CNT_W     = 32
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [1:0]                  i__mode,
   input  logic [RATE_W-1:0]           i__ejrate,
   input  logic [RATE_W-1:0]           i__seed,
   input  logic [7:0]                  i__burst_len,
   input  logic [7:0]                  i__gap_len,
   input  logic [CNT_W-1:0]            i__target_count,
   input  logic                        i__receive_phase,
   input  logic [NUM_PORTS-1:0]        i__pifo_ready,
   input  logic [NUM_PORTS*FLOW_W-1:0] i__packet_flow_id,
   input  logic [NUM_PORTS*PRIO_W-1:0] i__packet_priority,
   output logic [NUM_PORTS-1:0]        o__dequeue,
   output logic [NUM_PORTS*CNT_W-1:0]  o__num_pkts_recvd,
   output logic [NUM_PORTS-1:0]        o__order_error,
   output logic [NUM_PORTS*FLOW_W-1:0] o__last_flow_id,
   output logic                        o__done
);

   typedef enum logic {BURST, GAP} burst_t;

   // Maximal-length tap sets, shift-left Fibonacci form (bit n-1 = tap n).
   function automatic logic [31:0] lfsr_taps(input int w);
      case (w)
         2:       lfsr_taps = 32'h0000_0003;
         3:       lfsr_taps = 32'h0000_0006;
         4:       lfsr_taps = 32'h0000_000C;
         5:       lfsr_taps = 32'h0000_0014;
         6:       lfsr_taps = 32'h0000_0030;
         7:       lfsr_taps = 32'h0000_0060;
         8:       lfsr_taps = 32'h0000_00B8;
         9:       lfsr_taps = 32'h0000_0110;
         10:      lfsr_taps = 32'h0000_0240;
         11:      lfsr_taps = 32'h0000_0500;
         12:      lfsr_taps = 32'h0000_0829;
         13:      lfsr_taps = 32'h0000_100D;
         14:      lfsr_taps = 32'h0000_2015;
         15:      lfsr_taps = 32'h0000_6000;
         16:      lfsr_taps = 32'h0000_D008;
         default: lfsr_taps = 32'h8020_0003;
      endcase
   endfunction

   localparam logic [RATE_W-1:0] TAP_MASK = RATE_W'(lfsr_taps(RATE_W));

   logic                 phase_q;
   logic                 rise;
   logic [NUM_PORTS-1:0] reached;
   logic [7:0]           blen;
   logic [7:0]           glen;

   assign rise = i__receive_phase & ~phase_q;
   assign blen = (i__burst_len == 8'd0) ? 8'd1 : i__burst_len;
   assign glen = (i__gap_len == 8'd0) ? 8'd1 : i__gap_len;

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      localparam logic [RATE_W-1:0] PORT_ID = RATE_W'(p);

      burst_t            st, st_nxt;
      logic [7:0]        bc, bc_nxt;
      logic [8:0]        bc_inc;
      logic [RATE_W-1:0] lfsr;
      logic [RATE_W-1:0] seed_p;
      logic [CNT_W-1:0]  cnt;
      logic [PRIO_W-1:0] prio_in, prio_q;
      logic [FLOW_W-1:0] flow_in, flow_q;
      logic              gate, deq, pv, err, oerr;

      assign prio_in = i__packet_priority[p*PRIO_W +: PRIO_W];
      assign flow_in = i__packet_flow_id[p*FLOW_W +: FLOW_W];
      assign seed_p  = i__seed ^ PORT_ID;
      assign bc_inc  = {1'b0, bc} + 9'd1;

      always_comb begin
         gate = 1'b0;
         unique case (i__mode)
            2'd0:    gate = (lfsr < i__ejrate);
            2'd1:    gate = 1'b1;
            2'd2:    gate = (st == BURST);
            default: gate = 1'b0;
         endcase
      end

      assign deq = i__receive_phase & i__pifo_ready[p] & gate;
      // A rising phase edge starts a fresh, unordered sequence.
      assign err = deq & pv & ~rise & (prio_in < prio_q);

      always_comb begin
         st_nxt = st;
         bc_nxt = bc;
         if (i__mode == 2'd2) begin
            unique case (st)
               BURST: begin
                  if (deq) begin
                     if (bc_inc >= {1'b0, blen}) begin
                        st_nxt = GAP;
                        bc_nxt = 8'd0;
                     end else begin
                        bc_nxt = bc_inc[7:0];
                     end
                  end
               end
               GAP: begin
                  if (bc_inc >= {1'b0, glen}) begin
                     st_nxt = BURST;
                     bc_nxt = 8'd0;
                  end else begin
                     bc_nxt = bc_inc[7:0];
                  end
               end
               default: begin
                  st_nxt = BURST;
                  bc_nxt = 8'd0;
               end
            endcase
         end
      end

      always_ff @(posedge clk) begin
         if (!reset) begin
            st <= BURST;
            bc <= 8'd0;
         end else begin
            st <= st_nxt;
            bc <= bc_nxt;
         end
      end

      always_ff @(posedge clk) begin
         if (!reset) begin
            lfsr   <= (seed_p == '0) ? RATE_W'(1) : seed_p;
            cnt    <= '0;
            prio_q <= '0;
            flow_q <= '0;
            pv     <= 1'b0;
            oerr   <= 1'b0;
         end else begin
            if (deq) begin
               lfsr   <= {lfsr[RATE_W-2:0], ^(lfsr & TAP_MASK)};
               prio_q <= prio_in;
               flow_q <= flow_in;
               if (cnt != '1)
                  cnt <= cnt + CNT_W'(1);
            end
            pv <= deq | (pv & ~rise);
            if (err)
               oerr <= 1'b1;
         end
      end

      assign o__dequeue[p]                       = deq;
      assign o__order_error[p]                   = oerr;
      assign o__num_pkts_recvd[p*CNT_W +: CNT_W] = cnt;
      assign o__last_flow_id[p*FLOW_W +: FLOW_W] = flow_q;
      assign reached[p]                          = (cnt >= i__target_count);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         phase_q <= 1'b0;
         o__done <= 1'b0;
      end else begin
         phase_q <= i__receive_phase;
         if ((i__target_count != '0) && (&reached))
            o__done <= 1'b1;
      end
   end

endmodule

// File: tb/tb_multi_traffic_receiver.sv
// Directed bench for multi_traffic_receiver: greedy, burst/gap, random,
// order checking, phase restart, done logic and mid-run reset.
module tb_multi_traffic_receiver;

   localparam int NP = 2;
   localparam int FW = 8;
   localparam int PW = 16;
   localparam int RW = 8;
   localparam int CW = 32;

   logic           clk = 1'b0;
   logic           reset;
   logic [1:0]     mode;
   logic [RW-1:0]  ejrate, seed;
   logic [7:0]     burst_len, gap_len;
   logic [CW-1:0]  target;
   logic           phase;
   logic [NP-1:0]  ready;
   logic [NP*FW-1:0] flow;
   logic [NP*PW-1:0] prio;
   logic [NP-1:0]  deq;
   logic [NP*CW-1:0] cnt;
   logic [NP-1:0]  oerr;
   logic [NP*FW-1:0] lflow;
   logic           done;

   int n_chk  = 0;
   int n_pass = 0;

   int pl [4] = '{5, 5, 7, 4};
   int fl [4] = '{1, 2, 3, 4};
   logic run1 [300];

   always #5 clk = ~clk;

   multi_traffic_receiver #(
      .NUM_PORTS(NP), .FLOW_W(FW), .PRIO_W(PW), .RATE_W(RW), .CNT_W(CW)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .i__mode            (mode),
      .i__ejrate          (ejrate),
      .i__seed            (seed),
      .i__burst_len       (burst_len),
      .i__gap_len         (gap_len),
      .i__target_count    (target),
      .i__receive_phase   (phase),
      .i__pifo_ready      (ready),
      .i__packet_flow_id  (flow),
      .i__packet_priority (prio),
      .o__dequeue         (deq),
      .o__num_pkts_recvd  (cnt),
      .o__order_error     (oerr),
      .o__last_flow_id    (lflow),
      .o__done            (done)
   );

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   initial begin
      int t0, t1, viol, mism, c1;
      logic broke;
      logic [9:0] pat0, pat1;

      reset = 1'b0; mode = 2'd1; ejrate = '0; seed = 8'h5A;
      burst_len = 8'd3; gap_len = 8'd2; target = '0;
      phase = 1'b0; ready = '0; flow = '0; prio = '0;

      // reset state, dequeue stays combinational while in reset
      phase = 1'b1; ready = 2'b11; flow = {8'h3C, 8'hA5};
      tick(); tick();
      check("rst_cnt0", cnt[31:0], 0);
      check("rst_cnt1", cnt[63:32], 0);
      check("rst_oerr", oerr, 0);
      check("rst_lflow", lflow, 0);
      check("rst_done", done, 0);
      check("rst_deq_comb", deq, 2'b11);

      // greedy, 10 cycles
      reset = 1'b1; t0 = 0; t1 = 0;
      for (int i = 0; i < 10; i++) begin
         #1; t0 += deq[0]; t1 += deq[1];
         tick();
      end
      ready = '0;
      check("greedy_deq0", t0, 10);
      check("greedy_deq1", t1, 10);
      check("greedy_cnt0", cnt[31:0], 10);
      check("greedy_cnt1", cnt[63:32], 10);
      check("greedy_lflow", lflow, 16'h3CA5);
      check("greedy_oerr", oerr, 0);

      // burst 3 / gap 2
      mode = 2'd2; phase = 1'b1; ready = 2'b11;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         #1; pat0[i] = deq[0]; pat1[i] = deq[1];
         tick();
      end
      check("burst_pat0", pat0, 10'b0011100111);
      check("burst_pat1", pat1, 10'b0011100111);
      check("burst_cnt0", cnt[31:0], 6);
      mode = 2'd3; #1;
      check("halt_deq", deq, 0);

      // priority order on port 0
      mode = 2'd1; phase = 1'b0; ready = '0;
      do_reset();
      phase = 1'b1; ready = 2'b11;
      for (int i = 0; i < 4; i++) begin
         prio = {16'd3, 16'(pl[i])};
         flow = {8'h00, 8'(fl[i])};
         tick();
         if (i == 2) check("ord_before", oerr, 0);
      end
      check("ord_err", oerr, 2'b01);
      check("ord_lflow0", lflow[7:0], 4);
      prio = {16'd3, 16'd20}; tick(); ready = '0; tick();
      check("ord_sticky", oerr, 2'b01);

      // phase restart clears ordering history
      phase = 1'b0; ready = '0;
      do_reset();
      phase = 1'b1; ready = 2'b01; prio = {16'd0, 16'd9}; tick();
      phase = 1'b0; tick();
      phase = 1'b1; prio = {16'd0, 16'd2}; tick();
      ready = '0; tick();
      check("phase_no_err", oerr, 0);
      ready = 2'b01; prio = {16'd0, 16'd1}; tick();
      ready = '0; tick();
      check("phase_err_after", oerr, 2'b01);

      // done with target 4
      phase = 1'b0; ready = '0; prio = '0; target = 4;
      do_reset();
      phase = 1'b1; ready = 2'b11;
      repeat (3) tick();
      ready = 2'b01;
      repeat (3) tick();
      ready = '0; tick();
      check("done_short_cnt1", cnt[63:32], 3);
      check("done_short", done, 0);
      ready = 2'b10; tick();
      ready = '0;
      check("done_cnt1", cnt[63:32], 4);
      check("done_lag", done, 0);
      tick();
      check("done_set", done, 1);
      repeat (5) tick();
      check("done_sticky", done, 1);
      target = '0; ready = 2'b11;
      do_reset();
      repeat (6) tick();
      check("done_target0", done, 0);

      // random, ejrate 0
      mode = 2'd0; ejrate = 8'd0; seed = 8'h5A; ready = 2'b11; phase = 1'b1;
      do_reset();
      t0 = 0;
      for (int i = 0; i < 20; i++) begin
         #1; t0 += deq[0] + deq[1];
         tick();
      end
      check("rand_ej0_deq", t0, 0);
      check("rand_ej0_cnt", cnt, 0);

      // seed 0 forces port 0 to 1; port 1 is also 1 -> one dequeue each
      ejrate = 8'd2; seed = 8'h00;
      do_reset();
      #1;
      check("rand_seed0_first", deq, 2'b11);
      repeat (20) tick();
      check("rand_seed0_cnt0", cnt[31:0], 1);
      check("rand_seed0_cnt1", cnt[63:32], 1);

      // ejrate all-ones: port 0 starts at FF and never fires
      ejrate = 8'hFF; seed = 8'hFF;
      do_reset();
      t0 = 0; c1 = 0; viol = 0; broke = 1'b0;
      for (int i = 0; i < 300; i++) begin
         #1;
         t0 += deq[0];
         run1[i] = deq[1];
         c1 += deq[1];
         if (broke && deq[1]) viol++;
         if (!deq[1]) broke = 1'b1;
         tick();
      end
      check("rand_ff_port0", t0, 0);
      check("rand_ff_cnt0", cnt[31:0], 0);
      check("rand_ff_stall", viol, 0);
      check("rand_ff_range", (c1 >= 1) && (c1 <= 254), 1);
      check("rand_ff_cnt1", cnt[63:32], c1);

      // reset mid-run discards progress and replays the same sequence
      do_reset();
      repeat (40) tick();
      reset = 1'b0; tick();
      check("midrst_cnt", cnt, 0);
      reset = 1'b1;
      mism = 0;
      for (int i = 0; i < 300; i++) begin
         #1;
         if (deq[1] !== run1[i]) mism++;
         tick();
      end
      check("midrst_replay", mism, 0);
      check("midrst_cnt1", cnt[63:32], c1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
